// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// Parametrised universal shift register with parallel load and logical,
// arithmetic and rotate shifts. A multi-step shift runs one bit position per
// clock under a start/busy/done handshake.
//
// State table:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; LOAD/HOLD complete here in one edge
//   S_SHIFT | performing one single-bit step per edge until the count ends
//
// Ports:
//   clk     in   single clock, rising edge
//   rst     in   synchronous active-high reset, dominates all other inputs
//   start   in   command request, accepted only in S_IDLE
//   mode    in   command: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL,
//                101 ROR, 110 ASR, 111 reserved (HOLD)
//   amt     in   number of single-bit steps for a shift command
//   d       in   parallel load data (LOAD only)
//   sin_l   in   serial fill at the MSB side (SHR), sampled at each step
//   sin_r   in   serial fill at the LSB side (SHL), sampled at each step
//   q       out  register contents
//   sout_l  out  q[WIDTH-1]
//   sout_r  out  q[0]
//   busy    out  registered, high while a shift is in progress
//   done    out  registered, one-cycle completion pulse
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_RSVD = 3'b111;

    localparam logic [AMT_W-1:0] CNT_LAST = AMT_W'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_r, q_nx, q_step;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic [2:0]       op, op_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;
    logic             is_shift;

    // A command is a real shift only for the five shift encodings.
    always_comb begin
        is_shift = (mode != M_HOLD) && (mode != M_LOAD) && (mode != M_RSVD);
    end

    // One single-bit step of the latched operation; serial inputs are live.
    always_comb begin
        q_step = q_r;
        case (op)
            M_SHL:   q_step = {q_r[WIDTH-2:0], sin_r};
            M_SHR:   q_step = {sin_l, q_r[WIDTH-1:1]};
            M_ROL:   q_step = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            M_ROR:   q_step = {q_r[0], q_r[WIDTH-1:1]};
            M_ASR:   q_step = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            default: q_step = q_r;
        endcase
    end

    always_comb begin
        state_nx = state;
        q_nx     = q_r;
        cnt_nx   = cnt;
        op_nx    = op;
        busy_nx  = busy_r;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_nx = mode;
                    if (mode == M_LOAD) begin
                        q_nx    = d;
                        done_nx = 1'b1;
                    end else if (is_shift && (amt != '0)) begin
                        state_nx = S_SHIFT;
                        cnt_nx   = amt;
                        busy_nx  = 1'b1;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                q_nx   = q_step;
                cnt_nx = cnt - 1'b1;
                // Terminal count: this edge performs the final step.
                if (cnt == CNT_LAST) begin
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            q_r    <= '0;
            cnt    <= '0;
            op     <= M_HOLD;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            q_r    <= q_nx;
            cnt    <= cnt_nx;
            op     <= op_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
        end
    end

    assign q      = q_r;
    assign sout_l = q_r[WIDTH-1];
    assign sout_r = q_r[0];
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH = 8, AMT_W = 4): a command
// table, hand-written multi-cycle sequences, and random commands checked
// against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_RSVD = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .amt    (amt),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        int         amt;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [7:0] exp_q;
        int         exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one single-bit step expressed as plain arithmetic on 0..255.
    function automatic int model_step(input int m, input int op, input int sl, input int sr);
        case (op)
            2: return ((m * 2) % 256) + sr;
            3: return (m / 2) + sl * 128;
            4: return ((m * 2) % 256) + (m / 128);
            5: return (m / 2) + (m % 2) * 128;
            6: return (m / 2) + ((m >= 128) ? 128 : 0);
            default: return m;
        endcase
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        mode  = M_HOLD;
        amt   = '0;
        d     = '0;
        sin_l = 1'b0;
        sin_r = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one command, wait (bounded) for done, report busy length and q.
    task automatic run_cmd(input logic [2:0] m, input int a, input logic [7:0] dv,
                           input logic sl, input logic sr,
                           output logic [7:0] q_out, output int nbusy, output bit got);
        start = 1'b1;
        mode  = m;
        amt   = AMT_W'(a);
        d     = dv;
        sin_l = sl;
        sin_r = sr;
        tick();
        start = 1'b0;
        got   = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            tick();
        end
        q_out = q;
    endtask

    initial begin
        logic [7:0] qv;
        int         nb;
        bit         got;
        int         mq;
        int         dcount;

        vecs.push_back('{M_LOAD, 0,  8'hA5, 1'b0, 1'b0, 8'hA5, 0});
        vecs.push_back('{M_LOAD, 0,  8'h81, 1'b0, 1'b0, 8'h81, 0});
        vecs.push_back('{M_ROL,  3,  8'h00, 1'b0, 1'b0, 8'h0C, 3});
        vecs.push_back('{M_LOAD, 0,  8'h80, 1'b0, 1'b0, 8'h80, 0});
        vecs.push_back('{M_ASR,  2,  8'h00, 1'b0, 1'b0, 8'hE0, 2});
        vecs.push_back('{M_SHR,  2,  8'h00, 1'b0, 1'b0, 8'h38, 2});
        vecs.push_back('{M_LOAD, 0,  8'h01, 1'b0, 1'b0, 8'h01, 0});
        vecs.push_back('{M_SHL,  9,  8'h00, 1'b0, 1'b1, 8'hFF, 9});
        vecs.push_back('{M_SHL,  0,  8'h00, 1'b0, 1'b0, 8'hFF, 0});
        vecs.push_back('{M_HOLD, 5,  8'h12, 1'b1, 1'b1, 8'hFF, 0});
        vecs.push_back('{M_RSVD, 3,  8'h34, 1'b0, 1'b0, 8'hFF, 0});
        vecs.push_back('{M_LOAD, 0,  8'h96, 1'b0, 1'b0, 8'h96, 0});
        vecs.push_back('{M_ROR,  4,  8'h00, 1'b0, 1'b0, 8'h69, 4});
        vecs.push_back('{M_SHR,  3,  8'h00, 1'b1, 1'b0, 8'hED, 3});
        vecs.push_back('{M_ASR,  1,  8'h00, 1'b0, 1'b0, 8'hF6, 1});
        vecs.push_back('{M_ROL,  12, 8'h00, 1'b0, 1'b0, 8'h6F, 12});
        vecs.push_back('{M_ASR,  3,  8'h00, 1'b0, 1'b0, 8'h0D, 3});
        vecs.push_back('{M_SHL,  3,  8'h00, 1'b0, 1'b0, 8'h68, 3});

        do_reset();
        chk("reset_q", q, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sout", {sout_l, sout_r}, 0);

        // Command table
        foreach (vecs[i]) begin
            run_cmd(vecs[i].mode, vecs[i].amt, vecs[i].d, vecs[i].sl, vecs[i].sr, qv, nb, got);
            chk($sformatf("vec%0d_done", i), got, 1);
            chk($sformatf("vec%0d_q", i), qv, vecs[i].exp_q);
            chk($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].exp_busy);
            tick();
            chk($sformatf("vec%0d_done_width", i), done, 0);
        end

        // Serial outputs follow q directly
        run_cmd(M_LOAD, 0, 8'h81, 1'b0, 1'b0, qv, nb, got);
        chk("sout_81", {sout_l, sout_r}, 2'b11);
        run_cmd(M_LOAD, 0, 8'h40, 1'b0, 1'b0, qv, nb, got);
        chk("sout_40", {sout_l, sout_r}, 2'b00);

        // ROL 3 from 0x81, stepwise
        run_cmd(M_LOAD, 0, 8'h81, 1'b0, 1'b0, qv, nb, got);
        start = 1'b1; mode = M_ROL; amt = 4'd3;
        tick();
        start = 1'b0;
        chk("rol_e0_busy", busy, 1);
        chk("rol_e0_q", q, 8'h81);
        tick();
        chk("rol_e1_q", q, 8'h03);
        tick();
        chk("rol_e2_q", q, 8'h06);
        chk("rol_e2_busy", busy, 1);
        tick();
        chk("rol_e3_q", q, 8'h0C);
        chk("rol_e3_done_busy", {done, busy}, 2'b10);
        tick();
        chk("rol_after_done", {done, busy}, 2'b00);

        // start while busy ignored; start in done cycle accepted
        run_cmd(M_LOAD, 0, 8'h55, 1'b0, 1'b0, qv, nb, got);
        start = 1'b1; mode = M_SHL; amt = 4'd4; sin_r = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("busy_e1_q", q, 8'hAA);
        start = 1'b1; mode = M_LOAD; d = 8'hFF; amt = 4'd1;
        tick();
        start = 1'b0;
        chk("busy_ignore_q", q, 8'h54);
        chk("busy_ignore_busy", busy, 1);
        tick();
        tick();
        chk("busy_final_q", q, 8'h50);
        chk("busy_final_done", done, 1);
        start = 1'b1; mode = M_LOAD; d = 8'h3C;
        tick();
        start = 1'b0;
        chk("b2b_q", q, 8'h3C);
        chk("b2b_done_busy", {done, busy}, 2'b10);

        // Reset mid-ROR: aborted, no done, same-cycle start dropped
        run_cmd(M_LOAD, 0, 8'hF0, 1'b0, 1'b0, qv, nb, got);
        start = 1'b1; mode = M_ROR; amt = 4'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ror_mid_q", q, 8'h3C);
        rst = 1'b1; start = 1'b1; mode = M_LOAD; d = 8'hAA;
        tick();
        chk("rst_mid_q", q, 0);
        chk("rst_mid_busy_done", {busy, done}, 0);
        rst = 1'b0; start = 1'b0;
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) dcount++;
        end
        chk("rst_no_done", dcount, 0);
        chk("rst_q_stays", q, 0);

        // Random commands against the arithmetic model
        mq = 0;
        for (int it = 0; it < 80; it++) begin
            int m, a;
            m = int'($urandom_range(7, 0));
            a = int'($urandom_range(11, 0));
            start = 1'b1;
            mode  = 3'(m);
            amt   = AMT_W'(a);
            d     = 8'($urandom_range(255, 0));
            sin_l = 1'($urandom_range(1, 0));
            sin_r = 1'($urandom_range(1, 0));
            if (m == 1) mq = int'(d);
            tick();
            start = 1'b0;
            if (m >= 2 && m <= 6 && a > 0) begin
                for (int s = 0; s < a; s++) begin
                    chk($sformatf("rnd%0d_busy%0d", it, s), busy, 1);
                    sin_l = 1'($urandom_range(1, 0));
                    sin_r = 1'($urandom_range(1, 0));
                    // Occasional start during busy must have no effect.
                    start = 1'($urandom_range(3, 0) == 0);
                    mode  = 3'($urandom_range(7, 0));
                    d     = 8'($urandom_range(255, 0));
                    mq = model_step(mq, m, int'(sin_l), int'(sin_r));
                    tick();
                    start = 1'b0;
                    chk($sformatf("rnd%0d_step%0d_q", it, s), q, mq);
                end
            end else begin
                chk($sformatf("rnd%0d_q", it), q, mq);
            end
            chk($sformatf("rnd%0d_done_busy", it), {done, busy}, 2'b10);
            if ($urandom_range(1, 0) == 1) begin
                tick();
                chk($sformatf("rnd%0d_idle", it), {done, busy}, 2'b00);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register in the shift-register family. Adds configurable width, parallel load, and logical, arithmetic and rotate shifts in both directions. A multi-step shift runs under a start/busy/done handshake, one bit position per clock. It is the shift engine for the serialiser and barrel-shift exercises in the sequential-circuits set.

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- AMT_W, 4, width of the shift-amount input
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; dominates every other input
- start  input  1  request a command; accepted only in IDLE
- mode  input  3  command, sampled at accept: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 reserved (treated as HOLD)
- amt  input  AMT_W  number of single-bit steps, sampled at accept
- d  input  WIDTH  parallel load data, sampled at accept (LOAD only)
- sin_l  input  1  serial in at MSB side (SHR fill)
- sin_r  input  1  serial in at LSB side (SHL fill)
- q  output  WIDTH  register contents
- sout_l  output  1  q[WIDTH-1], combinational from q
- sout_r  output  1  q[0], combinational from q
- busy  output  1  registered; high while a multi-step shift is in progress
- done  output  1  registered; single-cycle completion pulse

## Operation
- States: IDLE, SHIFT. Reset sets state IDLE, q = 0, busy = 0, done = 0, and clears the step counter.
- Accept: start = 1 in IDLE at edge E0. The edge latches mode and amt. For LOAD it also captures d.
- LOAD: q <= d at E0. done = 1 for the cycle after E0. State stays IDLE. amt is ignored.
- HOLD, reserved, or amt = 0 with any shift mode: q is unchanged. done = 1 for the cycle after E0. State stays IDLE.
- Shift modes with amt ≥ 1: move to SHIFT at E0, counter = amt, busy = 1. Each later edge performs one step and decrements the counter.
- Per-step rules:
  - SHL: q <= {q[W-2:0], sin_r}
  - SHR: q <= {sin_l, q[W-1:1]}
  - ROL: q <= {q[W-2:0], q[W-1]}
  - ROR: q <= {q[0], q[W-1:1]}
  - ASR: q <= {q[W-1], q[W-1:1]}
- sin_l and sin_r are sampled live at each step edge, not latched at accept.
- amt > WIDTH is legal. Steps continue for the full count: rotates wrap, logical shifts keep filling from the serial input.
- The edge performing the final step also does the following: returns to IDLE, clears busy, sets done for one cycle.
- start while busy is ignored, with no queuing. Changes to mode, amt and d while busy have no effect.
- start in the cycle where done = 1 is accepted, because the state is already IDLE. This allows back-to-back commands.

## Timing
- Shift latency: q changes at edges E1..E_amt. busy is high during the cycles after E0 through E_amt. done is high for exactly the cycle after E_amt.
- LOAD/HOLD latency: one edge. done is high the cycle after E0. busy never asserts.
- Throughput: a shift of amt steps occupies amt+1 edges from accept to the next possible accept. LOAD and HOLD occupy 1 edge.
- Reset mid-shift: at the reset edge q = 0, busy = 0, done = 0, state IDLE. The operation is aborted and no done is issued. start in the same cycle as rst is dropped.
- sout_l and sout_r follow q with no extra register stage.

## Test plan
WIDTH = 8, AMT_W = 4 throughout.
- Reset, then LOAD d = 0xA5 -> q = 0xA5 and done pulses one cycle after the accept edge; busy stays 0.
- From q = 0x81, ROL with amt = 3 -> q steps 0x03, 0x06, 0x0C on successive edges; busy high for 3 cycles; done pulses once after the last step.
- From q = 0x80, ASR with amt = 2 -> q = 0xC0, then 0xE0. Then SHR with amt = 2 and sin_l = 0 -> q = 0x70, then 0x38.
- From q = 0x01, SHL with amt = 9 (> WIDTH) and sin_r = 1 held -> final q = 0xFF; busy lasts 9 cycles.
- During busy, pulse start with mode = LOAD -> ignored and q continues shifting. A start issued in the done cycle is accepted.
- Assert rst midway through a ROR with amt = 5 -> at the reset edge q = 0, busy = 0, and no done pulse occurs. amt = 0 SHL -> done pulse with q unchanged.
